// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle HI/LO multiply/divide sequencer.
// Runs MULT/MULTU as a shift-add and DIV/DIVU as a restoring divide,
// one bit per cycle on a shared accumulator. It owns the architectural
// HI/LO registers and serves MTHI/MTLO writes while idle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes are accepted here
// PREP  | take operand magnitudes, latch signs and divide-by-zero
// CALC  | WIDTH iterations of shift-add or restoring divide
// FIX   | apply sign corrections, write HI/LO, pulse done/dz
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         r_op;        // bit1: divide, bit0: signed
  logic [WIDTH-1:0]   r_a;         // multiplicand / dividend (shifts out MSB first in divide)
  logic [WIDTH-1:0]   r_b;         // multiplier (shifts out LSB first) / divisor
  logic [WIDTH-1:0]   r_a_orig;    // unmodified rs, returned in HI on divide-by-zero
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_dz;
  logic [2*WIDTH-1:0] r_acc;       // product, or {remainder, quotient}
  logic [CW-1:0]      r_cnt;

  logic               w_signed;
  logic               w_neg_res;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_rem_ge;
  logic [WIDTH-1:0]   w_rem_diff;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign busy      = (r_state != IDLE);
  assign w_signed  = r_op[0];
  assign w_neg_res = r_sign_a ^ r_sign_b;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit is set; the carry becomes the new MSB after the shift.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};

  // Divide step: the partial remainder needs WIDTH+1 bits because the
  // shifted-in dividend bit can push it past the largest divisor.
  // When the trial subtract succeeds the difference always fits in WIDTH bits.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
  assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;

  // Sign corrections are no-ops for unsigned ops because the sign flags
  // are only ever set for MULT/DIV.
  assign w_prod_fix = w_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = w_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sign_a ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  // Sequencer, datapath and architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_a_orig <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_dz     <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      if (r_state != IDLE && flush) begin
        // Squash: drop the operation without touching HI/LO.
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_op     <= op;
              r_a      <= a;
              r_b      <= b;
              r_a_orig <= a;
              r_state  <= PREP;
            end else begin
              if (mthi) hi <= wdata;
              if (mtlo) lo <= wdata;
            end
          end
          PREP: begin
            r_sign_a <= w_signed & r_a[WIDTH-1];
            r_sign_b <= w_signed & r_b[WIDTH-1];
            if (w_signed && r_a[WIDTH-1]) r_a <= ~r_a + 1'b1;
            if (w_signed && r_b[WIDTH-1]) r_b <= ~r_b + 1'b1;
            r_dz    <= r_op[1] && (r_b == '0);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= CALC;
          end
          CALC: begin
            if (!r_op[1]) begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
              r_b   <= r_b >> 1;
            end else begin
              if (w_rem_ge) begin
                r_acc <= {w_rem_diff, r_acc[WIDTH-2:0], 1'b1};
              end else begin
                r_acc <= {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
              end
              r_a <= r_a << 1;
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= FIX;
          end
          FIX: begin
            if (!r_op[1]) begin
              hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              lo <= w_prod_fix[WIDTH-1:0];
            end else if (r_dz) begin
              hi <= r_a_orig;
              lo <= '1;
            end else begin
              hi <= w_rem_fix;
              lo <= w_quo_fix;
            end
            done    <= 1'b1;
            dz      <= r_dz;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq against an
// arithmetic reference model (64-bit products, native / and %).
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {dz, hi, lo} for an operation.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int sx;
    int sy;
    if (o == 2'd0) begin
      p = {32'b0, x} * {32'b0, y};
      return {1'b0, p};
    end
    if (o == 2'd1) begin
      p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      return {1'b0, p};
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    if (o == 2'd2) return {1'b0, x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
    sx = $signed(x);
    sy = $signed(y);
    return {1'b0, 32'(sx % sy), 32'(sx / sy)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation: issue at E0, optionally with a same-cycle MTHI,
  // optionally poking start/mthi/mtlo while busy, then check timing and result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit mv, input bit poke);
    logic [64:0] e;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    int cyc;
    int busy_cnt;
    e = model(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    mthi = mv; wdata = 32'hDEAD_BEEF;
    hold_hi = hi;
    hold_lo = lo;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    cyc = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke && cyc == 3) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
      end
      if (poke && cyc == 6) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      if (cyc == 8) begin
        check("hold_hi", hi, hold_hi);
        check("hold_lo", lo, hold_lo);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd34);
    check("busy_cycles", 32'(busy_cnt), 32'd34);
    check("hi", hi, e[63:32]);
    check("lo", lo, e[31:0]);
    check("dz", 32'(dz), 32'(e[64]));
    @(posedge clk); #1;
    check("done_width", 32'(done), 32'd0);
    check("dz_width", 32'(dz), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_hi;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int ndone;

    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // MTHI and MTLO together in IDLE.
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_1234;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both_hi", hi, 32'hA5A5_1234);
    check("mt_both_lo", lo, 32'hA5A5_1234);

    // Directed operations.
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'd2, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    run_op(2'd3, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // start + mthi together: the move is dropped, the op runs.
    run_op(2'd0, 32'd3, 32'd4, 1'b1, 1'b0);
    // start/mthi/mtlo pulses while busy are ignored.
    run_op(2'd2, 32'hDEAD_0000, 32'd13, 1'b0, 1'b1);

    // Flush mid-CALC after preloading LO.
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'h0000_0055;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo_preload", lo, 32'h0000_0055);
    saved_hi = hi;
    @(negedge clk);
    op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("busy_before_flush", 32'(busy), 32'd1);
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_lo", lo, 32'h0000_0055);
    check("flush_hi", hi, saved_hi);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    check("flush_no_done", 32'(ndone), 32'd0);
    check("flush_lo_later", lo, 32'h0000_0055);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Random operations with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra = 32'd0;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'd1;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide operations (MULT, MULTU, DIV, DIVU) of the CPU datapath.
- Replaces single-cycle combinational `*`, `/` and `%` with a shared 32-iteration shift/add and restoring-divide engine.
- Owns the architectural HI and LO registers and serves MTHI/MTLO writes.
- Drives `busy` so the pipeline stalls any HI/LO consumer until results are written.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  abort the in-flight operation (exception/branch squash)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  data for MTHI/MTLO
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on the edge HI/LO are written
- dz  output  1  one-cycle pulse coincident with done when a DIV/DIVU divisor was 0
- hi  output  WIDTH  architectural HI register
- lo  output  WIDTH  architectural LO register

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - hi, lo, done and dz clear to 0; busy is 0.
  - All internal accumulators and the counter clear.
  - Reset mid-operation discards the operation.
- States: IDLE -> PREP -> CALC -> FIX -> IDLE.
- IDLE:
  - On start=1 at edge E0: latch op, a and b, and go to PREP.
  - If start, mthi and mtlo are asserted in the same cycle, start wins and the move is dropped.
  - Otherwise mthi/mtlo write HI/LO at that edge; both may be asserted together.
- PREP (1 cycle):
  - Signed ops: record sign_a and sign_b, then replace the operands with their absolute values (two's-complement negate, WIDTH-bit wrap).
  - Latch the divide-by-zero flag (b == 0, divide ops only).
  - Clear the 2*WIDTH accumulator and counter, then go to CALC.
- CALC (exactly WIDTH cycles; counter 0..WIDTH-1):
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring divide, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits wide.
  - Go to FIX when the counter reaches WIDTH-1.
- FIX (1 cycle, edge E34 relative to start at E0):
  - Apply sign corrections and write HI/LO.
  - Pulse done (and dz if applicable), then return to IDLE.
- Fixed latency for every op, including divide-by-zero: hi/lo hold new values and done=1 in the cycle after E34. busy is high from after E0 until after E34.
- Result rules:
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - MULT: product negated when sign_a ^ sign_b.
  - DIVU: lo = quotient, hi = remainder.
  - DIV: truncation toward zero. Quotient negated when sign_a ^ sign_b; remainder takes the sign of a.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wrap, no trap).
  - Divisor 0 (both divide ops): lo = 0xFFFFFFFF, hi = a (original value), dz pulses.
- While busy:
  - start is ignored; no queueing.
  - mthi/mtlo are ignored; the pipeline must stall them.
  - hi/lo hold their previous values until FIX.
- flush while busy: return to IDLE at the next edge, hi/lo unchanged, no done. A start in the same cycle as flush is also ignored.
- op, a and b may change after E0 without effect.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-CALC of a MULTU -> busy, done, hi and lo go to 0 immediately; after release, hi=lo=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after E34, hi=0xFFFFFFFE, lo=0x00000001, done for exactly 1 cycle, busy high for 34 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- Boundaries:
  - DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, dz=1 with done.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- Control interactions:
  - Preload via mtlo=1, wdata=0x55 in IDLE -> lo=0x55.
  - Then start a MULTU and assert flush at cycle 10 -> idle next cycle, lo=0x55, no done.
  - start+mthi in the same IDLE cycle -> op runs, mthi dropped.
  - start pulses while busy -> ignored.
